// File: rtl/xrv_mul_issue.sv
// Issue/writeback controller for the M-extension multiplier: issues ops to xrv_mult,
// stalls execute while a multiply is in flight, and handles zero fast path, flush drain and watchdog.
module xrv_mul_issue #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [2:0]  mul_type,
  output logic        mul_valid,
  input  logic [31:0] mul_result,
  input  logic        mul_result_valid,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       accept_s;
  logic       zero_op_s;
  logic       issue_s;
  logic       fast_s;
  logic       wb_load_s;
  logic       err_s;

  assign accept_s  = ex_valid & ~ex_funct3[2] & ~flush;
  assign zero_op_s = (ex_rs1 == 32'd0) | (ex_rs2 == 32'd0);

  // Next-state, watchdog countdown and combinational stall decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    issue_s     = 1'b0;
    fast_s      = 1'b0;
    wb_load_s   = 1'b0;
    err_s       = 1'b0;
    stall       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (ex_rd != 5'd0)) begin
          if (zero_op_s) begin
            fast_s = 1'b1;
          end else begin
            issue_s     = 1'b1;
            stall       = 1'b1;
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = TIMEOUT_C;
          end
        end else begin
          stall = 1'b0;
        end
      end
      ST_BUSY: begin
        if (mul_result_valid) begin
          // A result coinciding with flush belongs to the killed op and is dropped.
          wb_load_s   = ~flush;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r <= 8'd1) begin
          stall       = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          stall       = 1'b1;
          cnt_nxt_s   = cnt_r - 8'd1;
          state_nxt_s = flush ? ST_DRAIN : ST_BUSY;
        end
      end
      ST_DRAIN: begin
        stall = ex_valid & ~ex_funct3[2];
        if (mul_result_valid) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r <= 8'd1) begin
          err_s       = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, multiplier operand hold registers and writeback/err strobes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      mul_type  <= 3'd0;
      mul_valid <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mul_valid <= issue_s;
      wb_valid  <= fast_s | wb_load_s;
      err       <= err_s;
      if (issue_s) begin
        mul_a    <= ex_rs1;
        mul_b    <= ex_rs2;
        mul_type <= ex_funct3;
        wb_rd    <= ex_rd;
      end else if (fast_s) begin
        wb_rd    <= ex_rd;
      end
      if (fast_s) begin
        wb_data <= 32'd0;
      end else if (wb_load_s) begin
        wb_data <= mul_result;
      end
    end
  end

endmodule

// File: tb/tb_xrv_mul_issue.sv
// Directed self-checking bench for xrv_mul_issue; the multiplier is driven by hand.
module tb_xrv_mul_issue;
  logic        clk;
  logic        rstb;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [2:0]  mul_type;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic        mul_result_valid;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int checks;
  int failures;

  xrv_mul_issue #(.TIMEOUT(15)) dut (
    .clk(clk), .rstb(rstb), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .mul_a(mul_a), .mul_b(mul_b), .mul_type(mul_type), .mul_valid(mul_valid),
    .mul_result(mul_result), .mul_result_valid(mul_result_valid), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_funct3 = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0;
    flush = 1'b0; mul_result_valid = 1'b0; mul_result = 32'd0;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mul_a"}, mul_a, 32'd0);
    chk({tag, "_mul_b"}, mul_b, 32'd0);
    chk({tag, "_mul_type"}, {29'd0, mul_type}, 32'd0);
    chk({tag, "_mul_valid"}, {31'd0, mul_valid}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstb = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", {31'd0, stall}, 32'd0);
    rstb = 1'b1;
    tick();

    // MULHU 0xFFFFFFFF * 2, upper word = 1, result 5 cycles after issue
    present(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5);
    #1 chk("t1_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t1_mul_valid", {31'd0, mul_valid}, 32'd1);
    chk("t1_mul_type", {29'd0, mul_type}, 32'd3);
    chk("t1_mul_a", mul_a, 32'hFFFF_FFFF);
    chk("t1_mul_b", mul_b, 32'h0000_0002);
    #1 chk("t1_busy_stall", {31'd0, stall}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_wait_mul_valid", {31'd0, mul_valid}, 32'd0);
      chk("t1_wait_stall", {31'd0, stall}, 32'd1);
      chk("t1_wait_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("t1_wait_mul_a", mul_a, 32'hFFFF_FFFF);
    end
    tick();
    mul_result_valid = 1'b1;
    mul_result = 32'h0000_0001;
    #1 chk("t1_result_stall", {31'd0, stall}, 32'd0);
    chk("t1_result_mul_type", {29'd0, mul_type}, 32'd3);
    tick();
    idle_in();
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("t1_wb_data", wb_data, 32'h0000_0001);
    tick();
    chk("t1_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

    // Zero-operand fast path
    present(3'b000, 32'd0, 32'h0000_1234, 5'd7);
    #1 chk("t2_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    chk("t2_mul_valid", {31'd0, mul_valid}, 32'd0);
    chk("t2_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t2_wb_data", wb_data, 32'd0);
    chk("t2_wb_rd", {27'd0, wb_rd}, 32'd7);
    tick();

    // rd = x0 retires silently
    present(3'b000, 32'd3, 32'd4, 5'd0);
    #1 chk("t3_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    chk("t3_mul_valid", {31'd0, mul_valid}, 32'd0);
    chk("t3_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();

    // Divide op is ignored
    present(3'b100, 32'd3, 32'd4, 5'd9);
    #1 chk("t7_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t7_mul_valid", {31'd0, mul_valid}, 32'd0);
    chk("t7_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    idle_in();
    chk("t7_mul_valid2", {31'd0, mul_valid}, 32'd0);
    tick();

    // Flush two cycles after accept, new op waits through DRAIN
    present(3'b000, 32'd6, 32'd7, 5'd3);
    tick();
    chk("t4_mul_valid", {31'd0, mul_valid}, 32'd1);
    chk("t4_mul_a", mul_a, 32'd6);
    tick();
    ex_valid = 1'b0;
    flush = 1'b1;
    #1 chk("t4_flush_stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    present(3'b000, 32'd2, 32'd9, 5'd4);
    #1 chk("t4_drain_stall", {31'd0, stall}, 32'd1);
    chk("t4_drain_mul_valid", {31'd0, mul_valid}, 32'd0);
    tick();
    chk("t4_drain_stall2", {31'd0, stall}, 32'd1);
    tick();
    mul_result_valid = 1'b1;
    mul_result = 32'h0000_DEAD;
    #1 chk("t4_drain_result_stall", {31'd0, stall}, 32'd1);
    tick();
    mul_result_valid = 1'b0;
    chk("t4_discard_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t4_idle_mul_valid", {31'd0, mul_valid}, 32'd0);
    #1 chk("t4_reaccept_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t4_new_mul_valid", {31'd0, mul_valid}, 32'd1);
    chk("t4_new_mul_a", mul_a, 32'd2);
    chk("t4_new_mul_b", mul_b, 32'd9);
    chk("t4_new_wb_valid", {31'd0, wb_valid}, 32'd0);
    ex_valid = 1'b0;
    tick();
    mul_result_valid = 1'b1;
    mul_result = 32'd18;
    tick();
    idle_in();
    chk("t4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_wb_rd", {27'd0, wb_rd}, 32'd4);
    chk("t4_wb_data", wb_data, 32'd18);
    tick();

    // Flush coincident with result: result discarded
    present(3'b000, 32'd1, 32'd1, 5'd6);
    tick();
    ex_valid = 1'b0;
    flush = 1'b1;
    mul_result_valid = 1'b1;
    mul_result = 32'd1;
    tick();
    idle_in();
    chk("t8_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();

    // Watchdog: no result ever returned
    present(3'b001, 32'd5, 32'd5, 5'd8);
    tick();
    ex_valid = 1'b0;
    chk("t5_mul_valid", {31'd0, mul_valid}, 32'd1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("t5_wait_err", {31'd0, err}, 32'd0);
      chk("t5_wait_wb_valid", {31'd0, wb_valid}, 32'd0);
    end
    tick();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_err_wb_valid", {31'd0, wb_valid}, 32'd0);
    mul_result_valid = 1'b1;
    mul_result = 32'd25;
    #1 chk("t5_late_stall", {31'd0, stall}, 32'd0);
    tick();
    mul_result_valid = 1'b0;
    chk("t5_err_pulse_end", {31'd0, err}, 32'd0);
    chk("t5_late_wb_valid", {31'd0, wb_valid}, 32'd0);
    present(3'b000, 32'd3, 32'd3, 5'd2);
    #1 chk("t5_next_stall", {31'd0, stall}, 32'd1);
    tick();
    ex_valid = 1'b0;
    chk("t5_next_mul_valid", {31'd0, mul_valid}, 32'd1);
    tick();
    mul_result_valid = 1'b1;
    mul_result = 32'd9;
    tick();
    idle_in();
    chk("t5_next_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t5_next_wb_data", wb_data, 32'd9);
    tick();

    // Reset in the middle of BUSY, then a stale result
    present(3'b000, 32'h10, 32'h20, 5'd11);
    tick();
    ex_valid = 1'b0;
    chk("t6_mul_valid", {31'd0, mul_valid}, 32'd1);
    tick();
    rstb = 1'b0;
    #1 chk_all_zero("t6_reset");
    tick();
    rstb = 1'b1;
    tick();
    mul_result_valid = 1'b1;
    mul_result = 32'h200;
    #1 chk("t6_stale_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    chk_all_zero("t6_stale");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xrv_mul_issue.md
# xrv_mul_issue

Issue and writeback controller for the M-extension multiply unit. It sits between the execute stage and `xrv_mult`. It accepts MUL/MULH/MULHSU/MULHU operations from execute, and drives the multiplier's operand/type/valid inputs, holding them stable. It stalls the pipeline while the multiply is in flight, then returns the product to writeback as a single-cycle pulse. It also provides a zero-operand fast path, flush draining and a watchdog timeout.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles from issue to `mul_result_valid` before the watchdog fires. Legal range is 2..255.

- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute stage presents an M-extension op.
- `ex_funct3`  in  3  op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. If bit2 is set (divide), the op is ignored.
- `ex_rs1`, `ex_rs2`  in  32  operands. They are stable while `stall`=1.
- `ex_rd`  in  5  destination register.
- `flush`  in  1  kill in-flight and presented ops.
- `mul_a`, `mul_b`  out  32  multiplier operands.
- `mul_type`  out  3  multiplier type, equal to the `ex_funct3` captured at issue.
- `mul_valid`  out  1  single-cycle issue strobe.
- `mul_result`  in  32  multiplier result.
- `mul_result_valid`  in  1  multiplier result strobe.
- `stall`  out  1  combinational; holds the execute stage.
- `wb_valid`  out  1  single-cycle writeback strobe.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback data.
- `err`  out  1  single-cycle watchdog pulse.

## Operation
- An op is "accepted" when `ex_valid & ~ex_funct3[2] & ~flush` is true in IDLE.
- The controller has three states: IDLE, BUSY and DRAIN.
- IDLE, accepted op with `ex_rd`==0:
  - no issue, no writeback, `stall`=0.
  - the op retires silently.
- IDLE, accepted op with `ex_rd`!=0 and (`ex_rs1`==0 or `ex_rs2`==0):
  - fast path: no issue and `stall`=0.
  - the next cycle gives `wb_valid`=1, `wb_data`=0, `wb_rd`=`ex_rd`.
- IDLE, any other accepted op:
  - `stall`=1 in the accept cycle.
  - Register `mul_a`/`mul_b`/`mul_type`/`wb_rd` and pulse `mul_valid` in the next cycle.
  - Load the watchdog counter with `TIMEOUT` and go to BUSY.
- BUSY:
  - `stall`=1, except in a cycle where `mul_result_valid`=1; then `stall`=0 so execute advances in that cycle.
  - On `mul_result_valid`: register `wb_data`=`mul_result`, pulse `wb_valid` next cycle, go to IDLE.
- BUSY with `flush`=1 and no result:
  - go to DRAIN, since an in-flight multiply cannot be cancelled.
  - `flush` and `mul_result_valid` in the same cycle: the result is discarded, no `wb_valid`, go to IDLE.
- DRAIN:
  - Wait for `mul_result_valid`, discard it, go to IDLE.
  - `stall` = `ex_valid & ~ex_funct3[2]`, so a new op waits and is accepted in the first IDLE cycle.
  - Further `flush` has no effect.
- Watchdog:
  - In BUSY/DRAIN the counter decrements each cycle without `mul_result_valid`.
  - If it reaches 0: pulse `err`, no `wb_valid`, go to IDLE.
  - A late `mul_result_valid` arriving in IDLE is ignored.
- `mul_a`, `mul_b`, `mul_type` hold their issued values from the `mul_valid` cycle up to and including the cycle of `mul_result_valid`. `xrv_mult` reads `mul_type` and `mul_a[31]` at result time.
- Issued operand values are taken unmodified from `ex_rs1`/`ex_rs2`; sign handling belongs to the multiplier.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0. This covers `mul_a`, `mul_b`, `mul_type`, `mul_valid`, `wb_valid`, `wb_rd`, `wb_data` and `err`; `stall` is 0 because `ex_valid` is qualified by state.
- Reset applied mid-BUSY returns the controller to IDLE immediately. Any later `mul_result_valid` is ignored.
- Issue latency: accept at cycle N gives `mul_valid` at N+1.
- Writeback latency: `mul_result_valid` at cycle M gives `wb_valid` at M+1.
- Fast path: accept at N gives `wb_valid` at N+1.
- Back-to-back ops:
  - a new accept is possible in the cycle after `wb_valid`'s source cycle; IDLE is entered at M+1.
  - minimum spacing between two `mul_valid` pulses is 2 cycles after the result.
- `wb_valid` and `err` are never high in the same cycle. `mul_valid` is never high outside the first BUSY cycle.

## Test plan
- MULHU, rs1=0xFFFF_FFFF, rs2=0x0000_0002, rd=5, model returns after 5 cycles -> single `mul_valid` with `mul_type`=011; `stall` high until the result cycle; `wb_valid` with rd=5, data=0x0000_0001 one cycle later.
- MUL rs1=0, rs2=0x1234, rd=7 -> no `mul_valid`, `stall`=0, next cycle `wb_valid` with data=0.
- MUL rs1=3, rs2=4, rd=0 -> no `mul_valid`, no `wb_valid`, `stall`=0.
- Issue MUL, assert `flush` 2 cycles later; present a new MUL during DRAIN -> `stall` held; first result discarded (no `wb_valid`); new op issued in the cycle after the drain result.
- Model never returns result, `TIMEOUT`=15 -> `err` pulses exactly 15 cycles after `mul_valid`; no `wb_valid`; IDLE, and the next op is accepted.
- Drop `rstb` during BUSY, release, then the model returns a stale result -> all outputs 0 and the stale result is ignored.
- `ex_funct3`=100 (DIV) with `ex_valid` -> no `mul_valid`, `stall`=0, no `wb_valid`.
